// File: rtl/display_timing_generator.sv
// Display timing generator: sync/porch/active decode
// with registered outputs and a pixel-tick enable.
module display_timing_generator #(
  parameter int H_SYNC    = 1,
  parameter int H_BP      = 1,
  parameter int H_DISPLAY = 1,
  parameter int H_FP      = 1,
  parameter int V_SYNC    = 1,
  parameter int V_BP      = 1,
  parameter int V_DISPLAY = 1,
  parameter int V_FP      = 1,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  localparam int H_TOTAL =
    H_SYNC + H_BP + H_DISPLAY + H_FP,
  localparam int V_TOTAL =
    V_SYNC + V_BP + V_DISPLAY + V_FP,
  localparam int HX_BITS =
    (H_DISPLAY > 1) ? $clog2(H_DISPLAY) : 1,
  localparam int VY_BITS =
    (V_DISPLAY > 1) ? $clog2(V_DISPLAY) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               restart,
  output logic               hsync,
  output logic               vsync,
  output logic [3:0]         h_region,
  output logic [3:0]         v_region,
  output logic               de,
  output logic [HX_BITS-1:0] pixel_x,
  output logic [VY_BITS-1:0] pixel_y,
  output logic               line_start,
  output logic               frame_start
);

  localparam int HC_BITS =
    (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VC_BITS =
    (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [HC_BITS-1:0] H_BP_AT =
    HC_BITS'(H_SYNC);
  localparam logic [HC_BITS-1:0] H_DI_AT =
    HC_BITS'(H_SYNC + H_BP);
  localparam logic [HC_BITS-1:0] H_FP_AT =
    HC_BITS'(H_SYNC + H_BP + H_DISPLAY);
  localparam logic [HC_BITS-1:0] H_LAST =
    HC_BITS'(H_TOTAL - 1);

  localparam logic [VC_BITS-1:0] V_BP_AT =
    VC_BITS'(V_SYNC);
  localparam logic [VC_BITS-1:0] V_DI_AT =
    VC_BITS'(V_SYNC + V_BP);
  localparam logic [VC_BITS-1:0] V_FP_AT =
    VC_BITS'(V_SYNC + V_BP + V_DISPLAY);
  localparam logic [VC_BITS-1:0] V_LAST =
    VC_BITS'(V_TOTAL - 1);

  logic [HC_BITS-1:0] h_cnt, h_nxt, h_off;
  logic [VC_BITS-1:0] v_cnt, v_nxt, v_off;
  logic [3:0]         h_reg_d, v_reg_d;
  logic               de_d;
  logic [HX_BITS-1:0] px_d;
  logic [VY_BITS-1:0] py_d;

  // Region decode of the position about to be emitted.
  always_comb begin
    h_reg_d = 4'b1000;
    if (h_cnt < H_BP_AT)      h_reg_d = 4'b0001;
    else if (h_cnt < H_DI_AT) h_reg_d = 4'b0010;
    else if (h_cnt < H_FP_AT) h_reg_d = 4'b0100;
    v_reg_d = 4'b1000;
    if (v_cnt < V_BP_AT)      v_reg_d = 4'b0001;
    else if (v_cnt < V_DI_AT) v_reg_d = 4'b0010;
    else if (v_cnt < V_FP_AT) v_reg_d = 4'b0100;
    de_d  = h_reg_d[2] & v_reg_d[2];
    h_off = h_cnt - H_DI_AT;
    v_off = v_cnt - V_DI_AT;
    px_d  = de_d ? h_off[HX_BITS-1:0] : '0;
    py_d  = de_d ? v_off[VY_BITS-1:0] : '0;
  end

  // Raster advance: h wraps each line, v wraps with the last h.
  always_comb begin
    h_nxt = h_cnt + HC_BITS'(1);
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0
            : v_cnt + VC_BITS'(1);
    end
  end

  // Counters and registered outputs; restart beats enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      h_region    <= '0;
      v_region    <= '0;
      de          <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (restart) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      h_region    <= '0;
      v_region    <= '0;
      de          <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (enable) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      hsync       <= h_reg_d[0] ? HSYNC_POL
                                : ~HSYNC_POL;
      vsync       <= v_reg_d[0] ? VSYNC_POL
                                : ~VSYNC_POL;
      h_region    <= h_reg_d;
      v_region    <= v_reg_d;
      de          <= de_d;
      pixel_x     <= px_d;
      pixel_y     <= py_d;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_display_timing_generator.sv
// Bench for display_timing_generator: raster model
// compared every cycle plus literal anchor checks.
module tb_display_timing_generator;

  typedef struct {
    bit       hs;
    bit       vs;
    bit [3:0] hr;
    bit [3:0] vr;
    bit       de;
    int       px;
    int       py;
    bit       ls;
    bit       fs;
  } out_t;

  logic clk = 1'b0;
  logic rst, enable, restart, en2, rs2;
  logic hsync, vsync, de, line_start, frame_start;
  logic [3:0] h_region, v_region;
  logic [1:0] pixel_x, pixel_y;
  logic hsync2, vsync2, de2, ls2, fs2;
  logic [3:0] h_region2, v_region2;
  logic [0:0] pixel_x2, pixel_y2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  display_timing_generator #(
    .H_SYNC(2), .H_BP(2), .H_DISPLAY(4), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_DISPLAY(3), .V_FP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .enable(enable), .restart(restart),
    .hsync(hsync), .vsync(vsync),
    .h_region(h_region), .v_region(v_region),
    .de(de), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .line_start(line_start),
    .frame_start(frame_start)
  );

  display_timing_generator dut_b (
    .clk(clk), .rst(rst),
    .enable(en2), .restart(rs2),
    .hsync(hsync2), .vsync(vsync2),
    .h_region(h_region2), .v_region(v_region2),
    .de(de2), .pixel_x(pixel_x2), .pixel_y(pixel_y2),
    .line_start(ls2), .frame_start(fs2)
  );

  function automatic bit [3:0] region(
    int c, int s, int b, int d);
    if (c < s) return 4'b0001;
    if (c < s + b) return 4'b0010;
    if (c < s + b + d) return 4'b0100;
    return 4'b1000;
  endfunction

  function automatic out_t decode(
    int h, int v,
    int hs, int hb, int hd,
    int vs, int vb, int vd,
    bit hp, bit vp);
    out_t o;
    o.hr = region(h, hs, hb, hd);
    o.vr = region(v, vs, vb, vd);
    o.hs = o.hr[0] ? hp : ~hp;
    o.vs = o.vr[0] ? vp : ~vp;
    o.de = o.hr[2] && o.vr[2];
    o.px = o.de ? h - hs - hb : 0;
    o.py = o.de ? v - vs - vb : 0;
    o.ls = (h == 0);
    o.fs = (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic out_t idle(bit hp, bit vp);
    out_t o;
    o = '{hs: ~hp, vs: ~vp, hr: 0, vr: 0,
          de: 0, px: 0, py: 0, ls: 0, fs: 0};
    return o;
  endfunction

  function automatic bit same(out_t a, out_t b);
    return a.hs == b.hs && a.vs == b.vs &&
           a.hr == b.hr && a.vr == b.vr &&
           a.de == b.de && a.px == b.px &&
           a.py == b.py && a.ls == b.ls &&
           a.fs == b.fs;
  endfunction

  function automatic out_t got_a();
    out_t o;
    o = '{hs: hsync, vs: vsync, hr: h_region,
          vr: v_region, de: de, px: int'(pixel_x),
          py: int'(pixel_y), ls: line_start,
          fs: frame_start};
    return o;
  endfunction

  function automatic out_t got_b();
    out_t o;
    o = '{hs: hsync2, vs: vsync2, hr: h_region2,
          vr: v_region2, de: de2, px: int'(pixel_x2),
          py: int'(pixel_y2), ls: ls2, fs: fs2};
    return o;
  endfunction

  task automatic report(string n, out_t g, out_t e);
    checks++;
    if (!same(g, e)) begin
      failures++;
      $display("FAIL %s t=%0t got %p required %p",
               n, $time, g, e);
    end
  endtask

  task automatic chk(string n, int g, int e);
    checks++;
    if (g != e) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d",
               n, g, e);
    end
  endtask

  // Model: p is the linear index of the next position to emit.
  int   p1, p2;
  out_t e1, e2;

  always @(posedge clk or posedge rst) begin
    if (rst || restart) begin
      p1 = 0;
      e1 = idle(1'b0, 1'b1);
    end else if (enable) begin
      e1 = decode(p1 % 10, (p1 / 10) % 6,
                  2, 2, 4, 1, 1, 3, 1'b0, 1'b1);
      p1 = (p1 + 1) % 60;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst || rs2) begin
      p2 = 0;
      e2 = idle(1'b1, 1'b1);
    end else if (en2) begin
      e2 = decode(p2 % 4, (p2 / 4) % 4,
                  1, 1, 1, 1, 1, 1, 1'b1, 1'b1);
      p2 = (p2 + 1) % 16;
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    report("dut_a", got_a(),
           rst ? idle(1'b0, 1'b1) : e1);
    report("dut_b", got_b(),
           rst ? idle(1'b1, 1'b1) : e2);
  end

  task automatic step(bit en, bit rs);
    enable  = en;
    restart = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(int target);
    int guard;
    guard = 0;
    while (p1 != target && guard < 100) begin
      step(1'b1, 1'b0);
      guard++;
    end
    chk("run_to_bound", int'(p1 == target), 1);
  endtask

  initial begin
    int nfs, nls, nde;
    logic [3:0] prev;
    rst = 1'b1; enable = 1'b0; restart = 1'b0;
    en2 = 1'b0; rs2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 0);
    chk("rst_hreg", h_region, 0);
    chk("rst_fs", frame_start, 0);
    rst = 1'b0;
    en2 = 1'b1;

    nfs = 0; nls = 0; nde = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 1'b0);
      nfs += frame_start;
      nls += line_start;
      nde += de;
      if (i == 0) begin
        chk("first_fs", frame_start, 1);
        chk("first_ls", line_start, 1);
        chk("first_hsync", hsync, 0);
        chk("first_vsync", vsync, 1);
        chk("first_hreg", h_region, 1);
      end
      if (i == 24) begin
        chk("px_h4v2", pixel_x, 0);
        chk("de_h4v2", de, 1);
      end
      if (i == 47) begin
        chk("px_h7v4", pixel_x, 3);
        chk("py_h7v4", pixel_y, 2);
      end
    end
    chk("frame_fs_count", nfs, 1);
    chk("frame_ls_count", nls, 6);
    chk("frame_de_count", nde, 12);

    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("idle1_ls", line_start, 1);
    step(1'b0, 1'b0);
    chk("idle2_ls", line_start, 1);
    chk("idle2_fs", frame_start, 1);
    step(1'b1, 1'b0);
    chk("after_idle_ls", line_start, 0);
    chk("after_idle_hreg", h_region, 1);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0);

    step(1'b0, 1'b1);
    run_to(36);
    step(1'b1, 1'b1);
    chk("restart_hreg", h_region, 0);
    chk("restart_hsync", hsync, 1);
    step(1'b1, 1'b0);
    chk("post_restart_fs", frame_start, 1);
    chk("post_restart_hreg", h_region, 1);
    chk("post_restart_vreg", v_region, 1);

    run_to(59);
    step(1'b1, 1'b0);
    chk("h9v5_hsync", hsync, 1);
    chk("h9v5_vsync", vsync, 0);
    step(1'b1, 1'b0);
    chk("wrap_fs", frame_start, 1);
    chk("wrap_hsync", hsync, 0);
    chk("wrap_vsync", vsync, 1);

    repeat (3) step(1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_hsync", hsync, 1);
    chk("async_vsync", vsync, 0);
    chk("async_hreg", h_region, 0);
    chk("async_ls", line_start, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 1'b0);
    chk("post_rst_hsync", hsync, 0);
    chk("post_rst_fs", frame_start, 1);

    nde = 0;
    prev = h_region2;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0);
      chk("ones_rotate", h_region2,
          {prev[2:0], prev[3]});
      prev = h_region2;
      nde += de2;
    end
    chk("ones_de_count", nde, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/display_timing_generator.md
DISPLAY_TIMING_GENERATOR -- requirements
Module: display_timing_generator

Interface
REQ-001 The parameters SHALL be, one per line, name, default and meaning:
- H_SYNC, 1: horizontal sync width, in pixel-enable ticks, minimum 1.
- H_BP, 1: horizontal back porch width, minimum 1.
- H_DISPLAY, 1: horizontal active width, minimum 1.
- H_FP, 1: horizontal front porch width, minimum 1.
- V_SYNC, V_BP, V_DISPLAY, V_FP, each 1: vertical equivalents, in lines, each minimum 1.
- HSYNC_POL, 1: active level of hsync (1 = active-high).
- VSYNC_POL, 1: active level of vsync.
REQ-002 Derived constants SHALL be H_TOTAL = H_SYNC+H_BP+H_DISPLAY+H_FP, V_TOTAL likewise, HX_BITS = max(1, clog2(H_DISPLAY)) and VY_BITS = max(1, clog2(V_DISPLAY)).
REQ-003 The ports SHALL be, one per line, name, direction, width and meaning:
- clk, in, 1: the single clock.
- rst, in, 1: asynchronous, active-high reset.
- enable, in, 1: pixel tick; the position advances only when this is high.
- restart, in, 1: synchronous return to frame origin.
- hsync, out, 1: horizontal sync at the HSYNC_POL level while in the H sync region.
- vsync, out, 1: vertical sync at the VSYNC_POL level while in the V sync region.
- h_region, out, 4: one-hot horizontal region {fp, display, bp, sync}, MSB to LSB.
- v_region, out, 4: one-hot vertical region, same bit order.
- de, out, 1: data enable, high in H display AND V display.
- pixel_x, out, HX_BITS: display-relative column; valid when de is high, otherwise 0.
- pixel_y, out, VY_BITS: display-relative row; valid when de is high, otherwise 0.
- line_start, out, 1: one-tick pulse when the emitted position has h = 0.
- frame_start, out, 1: one-tick pulse when the emitted position has h = 0 and v = 0.

Function
REQ-004 The block SHALL hold internal counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1), which give the next position to emit.
REQ-005 On a clk edge with enable=1 and restart=0, all outputs SHALL register the decode of (h_cnt, v_cnt), and the counters SHALL then advance.
REQ-006 Output latency SHALL be exactly one clk after the enabling edge.
REQ-007 Advance rule: h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments; v_cnt wraps from V_TOTAL-1 to 0 on the same edge that h_cnt wraps.
REQ-008 With enable=0 and restart=0, counters and all outputs SHALL hold their values, including line_start and frame_start.
REQ-009 Since pulses hold while enable is low, line_start and frame_start SHALL be defined as lasting one enabled tick.
REQ-010 Horizontal region boundaries SHALL be: sync for [0, H_SYNC); bp for [H_SYNC, H_SYNC+H_BP); display for the next H_DISPLAY positions; fp for the rest up to H_TOTAL-1.
REQ-011 Exactly one h_region bit SHALL be set after the first enabled tick, and likewise for v_region.
REQ-012 pixel_x SHALL equal h - (H_SYNC+H_BP) and pixel_y SHALL equal v - (V_SYNC+V_BP) when de is high; both SHALL be 0 otherwise.
REQ-013 Counter widths SHALL be clog2(H_TOTAL) and clog2(V_TOTAL), with a minimum of 1; no out-of-range value is ever reachable.
REQ-014 restart=1 on a clk edge SHALL load h_cnt=0 and v_cnt=0 and drive all outputs to their reset values, regardless of enable; restart wins over enable.
REQ-015 After a restart, the next enabled tick SHALL emit position (0,0) with frame_start=1.
REQ-016 A degenerate case with all sizes equal to 1 (H_TOTAL=4) SHALL be legal and SHALL cycle through the regions in order.

Reset
REQ-017 While rst is high, h_cnt=0, v_cnt=0, h_region=0, v_region=0, de=0, pixel_x=0, pixel_y=0, line_start=0 and frame_start=0.
REQ-018 While rst is high, hsync=~HSYNC_POL and vsync=~VSYNC_POL, i.e. the inactive levels.
REQ-019 Assertion of rst SHALL take effect immediately, with no clock required; deassertion SHALL be synchronous to clk.
REQ-020 The first enabled tick after reset SHALL emit (0,0) with frame_start=1, line_start=1 and hsync/vsync at their active levels.
REQ-021 Reset mid-frame SHALL discard the current position without completing the line.

Verification
Parameters for the directed scenarios are H = 2/2/4/2 (H_TOTAL=10) and V = 1/1/3/1 (V_TOTAL=6).
REQ-022 Continuous enable for 60 ticks -> frame_start exactly at ticks 1 and 61-equivalent; 6 line_start pulses per frame; de high 12 ticks per frame; pixel_x runs 0..3 for ticks h=4..7; pixel_y runs 0..2.
REQ-023 Enable toggling 1,0,0,1 -> outputs change only on the enabled edges; a line_start pulse spans the two idle cycles with no double count; the position sequence is identical to the continuous-enable case.
REQ-024 restart asserted at h=6, v=3 with enable=1 -> next cycle shows reset values; the next enabled tick gives frame_start=1, h_region=0001, v_region=0001.
REQ-025 rst asserted asynchronously mid-line -> outputs immediately take the REQ-017/REQ-018 values; with HSYNC_POL=0, hsync reads 1 during reset and 0 at the first enabled tick.
REQ-026 Wrap check at h=9, v=5 -> the next tick is h=0, v=0, frame_start=1, and vsync goes active in the same cycle as hsync.
REQ-027 All-ones parameters -> the region one-hots rotate sync, bp, display, fp every tick, and de is high once per 16 ticks.
